powertrain_shift_ctrl: RTL

Parametrised N-speed automatic transmission controller with a cycle-accurate shift state machine, replacing the combinational gear and RPM lookup of the vehicle physics block. It consumes the existing speed, selector and accelerator signals and produces the gear number, a shift-in-progress torque-cut flag and a slew-limited RPM. Its outputs feed the dashboard/FND, the fuel and temperature model, and the physics block, which holds acceleration while torque_cut=1.

---
 rtl/powertrain_pkg.sv | 41 ++++
 rtl/powertrain_shift_ctrl_if.sv | 31 +++
 rtl/rpm_slew_limiter.sv | 34 +++
 rtl/powertrain_shift_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/powertrain_pkg.sv
// rtl/powertrain_pkg.sv - selector codes, shift FSM states and gear threshold helpers
package powertrain_pkg;

  localparam logic [3:0] SEL_P = 4'd3;
  localparam logic [3:0] SEL_R = 4'd6;
  localparam logic [3:0] SEL_N = 4'd9;
  localparam logic [3:0] SEL_D = 4'd12;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_HOLD     = 2'd1;
  localparam logic [1:0] ST_SHIFT_UP = 2'd2;
  localparam logic [1:0] ST_SHIFT_DN = 2'd3;

  // Per-gear RPM per km/h; ratio_1 is a parameter so every arm folds to a constant.
  function automatic int ratio_for_gear(input int ratio_1, input int g);
    case (g)
      1:       return ratio_1;
      2:       return ratio_1 / 2;
      3:       return ratio_1 / 3;
      4:       return ratio_1 / 4;
      5:       return ratio_1 / 5;
      6:       return ratio_1 / 6;
      7:       return ratio_1 / 7;
      8:       return ratio_1 / 8;
      default: return ratio_1;
    endcase
  endfunction

  function automatic int up_thresh(input int g, input int step);
    return g * step;
  endfunction

  function automatic int dn_thresh(input int g, input int step, input int hyst);
    return (g - 1) * step - hyst;
  endfunction

  function automatic int kick_thresh(input int g, input int step);
    return (g - 1) * step + step / 2;
  endfunction

endpackage

// File: rtl/powertrain_shift_ctrl_if.sv
// rtl/powertrain_shift_ctrl_if.sv - driver inputs and gear/rpm outputs of the shift controller
interface powertrain_shift_ctrl_if #(
  parameter int SPEED_W = 8,
  parameter int GEAR_W  = 3,
  parameter int RPM_W   = 14
);
  logic               engine_on;
  logic               tick_speed;
  logic [SPEED_W-1:0] speed;
  logic [3:0]         sel_mode;
  logic               low_gear_mode;
  logic [GEAR_W-1:0]  max_gear_limit;
  logic [7:0]         accel;
  logic [GEAR_W-1:0]  gear_num;
  logic               shifting;
  logic               torque_cut;
  logic               shift_up_pulse;
  logic               shift_dn_pulse;
  logic [RPM_W-1:0]   rpm;
  logic               over_rev;

  modport master (
    output engine_on, tick_speed, speed, sel_mode, low_gear_mode, max_gear_limit, accel,
    input  gear_num, shifting, torque_cut, shift_up_pulse, shift_dn_pulse, rpm, over_rev
  );

  modport slave (
    input  engine_on, tick_speed, speed, sel_mode, low_gear_mode, max_gear_limit, accel,
    output gear_num, shifting, torque_cut, shift_up_pulse, shift_dn_pulse, rpm, over_rev
  );
endinterface

// File: rtl/rpm_slew_limiter.sv
// rtl/rpm_slew_limiter.sv - moves rpm toward target by at most SLEW per tick
module rpm_slew_limiter #(
  parameter int W    = 14,
  parameter int SLEW = 200
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         clear,
  input  logic [W-1:0] target,
  output logic [W-1:0] rpm
);

  logic [W-1:0] diff_up;
  logic [W-1:0] diff_dn;

  assign diff_up = target - rpm;
  assign diff_dn = rpm - target;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpm <= '0;
    end else if (clear) begin
      rpm <= '0;
    end else if (tick) begin
      if (target > rpm) begin
        rpm <= (diff_up > W'(SLEW)) ? rpm + W'(SLEW) : target;
      end else if (target < rpm) begin
        rpm <= (diff_dn > W'(SLEW)) ? rpm - W'(SLEW) : target;
      end
    end
  end

endmodule

// File: rtl/powertrain_shift_ctrl.sv
// rtl/powertrain_shift_ctrl.sv - N-speed automatic shift FSM with slew-limited engine rpm
module powertrain_shift_ctrl
  import powertrain_pkg::*;
#(
  parameter int NUM_GEARS     = 6,
  parameter int SPEED_W       = 8,
  parameter int RPM_W         = 14,
  parameter int GEAR_W        = 3,
  parameter int SHIFT_STEP    = 30,
  parameter int HYST          = 5,
  parameter int SHIFT_TICKS   = 4,
  parameter int KICK_THR      = 200,
  parameter int IDLE_RPM      = 800,
  parameter int RATIO_1       = 60,
  parameter int NEUTRAL_LIMIT = 4000,
  parameter int REDLINE       = 8000,
  parameter int RPM_SLEW      = 200
) (
  input  logic                   clk,
  input  logic                   rst,
  powertrain_shift_ctrl_if.slave bus
);

  localparam int TW    = RPM_W + 4;
  localparam int CNT_W = (SHIFT_TICKS > 1) ? $clog2(SHIFT_TICKS) : 1;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [GEAR_W-1:0] gear_num;
  logic              up_pulse, dn_pulse, over_rev;
  logic              drive_ok, in_dr;
  logic              dn_req, up_req;
  int                g_i, spd_i, lim_i;
  logic [TW-1:0]     ratio_v, raw_dr, raw_pn;
  logic [RPM_W-1:0]  target, rpm_q;

  assign drive_ok = bus.engine_on && (bus.sel_mode == SEL_D);
  assign in_dr    = (bus.sel_mode == SEL_D) || (bus.sel_mode == SEL_R);
  assign g_i      = int'(gear_num);
  assign spd_i    = int'(bus.speed);

  always_comb begin
    lim_i = NUM_GEARS;
    if (bus.low_gear_mode && bus.sel_mode == SEL_D) begin
      if (bus.max_gear_limit == '0)                    lim_i = 1;
      else if (int'(bus.max_gear_limit) > NUM_GEARS)   lim_i = NUM_GEARS;
      else                                             lim_i = int'(bus.max_gear_limit);
    end
  end

  // HOLD decision, highest priority first: gear cap, kickdown, coast-down, upshift.
  always_comb begin
    dn_req = 1'b0;
    up_req = 1'b0;
    if (g_i > lim_i)
      dn_req = 1'b1;
    else if (int'(bus.accel) >= KICK_THR && g_i > 1 && spd_i < kick_thresh(g_i, SHIFT_STEP))
      dn_req = 1'b1;
    else if (spd_i < dn_thresh(g_i, SHIFT_STEP, HYST))
      dn_req = 1'b1;
    else if (g_i < lim_i && spd_i >= up_thresh(g_i, SHIFT_STEP))
      up_req = 1'b1;
  end

  // Target uses the engaged gear, so it stays on the old ratio until the shift completes.
  assign ratio_v = TW'(ratio_for_gear(RATIO_1, g_i));
  assign raw_dr  = TW'(IDLE_RPM) + TW'(bus.speed) * ratio_v + (TW'(bus.accel) << 1);
  assign raw_pn  = TW'(IDLE_RPM) + TW'(bus.accel) * TW'(20);

  always_comb begin
    target = '0;
    if (bus.engine_on) begin
      if (in_dr)
        target = (raw_dr >= TW'(REDLINE)) ? RPM_W'(REDLINE) : raw_dr[RPM_W-1:0];
      else
        target = (raw_pn >= TW'(NEUTRAL_LIMIT)) ? RPM_W'(NEUTRAL_LIMIT) : raw_pn[RPM_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      gear_num <= GEAR_W'(1);
      up_pulse <= 1'b0;
      dn_pulse <= 1'b0;
      over_rev <= 1'b0;
    end else begin
      up_pulse <= 1'b0;
      dn_pulse <= 1'b0;
      if (bus.tick_speed)
        over_rev <= bus.engine_on && in_dr && (raw_dr >= TW'(REDLINE));
      if (!drive_ok) begin
        state    <= ST_IDLE;
        cnt      <= '0;
        gear_num <= GEAR_W'(1);
      end else if (bus.tick_speed) begin
        case (state)
          ST_IDLE: state <= ST_HOLD;
          ST_HOLD: begin
            if (dn_req) begin
              state <= ST_SHIFT_DN;
              cnt   <= CNT_W'(SHIFT_TICKS - 1);
            end else if (up_req) begin
              state <= ST_SHIFT_UP;
              cnt   <= CNT_W'(SHIFT_TICKS - 1);
            end
          end
          ST_SHIFT_UP: begin
            if (cnt == '0) begin
              gear_num <= gear_num + GEAR_W'(1);
              up_pulse <= 1'b1;
              state    <= ST_HOLD;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          ST_SHIFT_DN: begin
            if (cnt == '0) begin
              gear_num <= gear_num - GEAR_W'(1);
              dn_pulse <= 1'b1;
              state    <= ST_HOLD;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  rpm_slew_limiter #(
    .W    (RPM_W),
    .SLEW (RPM_SLEW)
  ) u_slew (
    .clk    (clk),
    .rst    (rst),
    .tick   (bus.tick_speed),
    .clear  (!bus.engine_on),
    .target (target),
    .rpm    (rpm_q)
  );

  assign bus.gear_num       = gear_num;
  assign bus.shifting       = (state == ST_SHIFT_UP) || (state == ST_SHIFT_DN);
  assign bus.torque_cut     = bus.shifting;
  assign bus.shift_up_pulse = up_pulse;
  assign bus.shift_dn_pulse = dn_pulse;
  assign bus.rpm            = rpm_q;
  assign bus.over_rev       = over_rev;

endmodule
